// File: rtl/stopwatch_display_driver_pkg.sv
// Shared definitions for the stopwatch MAX7219 driver: register map, init data,
// controller/transmitter state encodings and frame-building helpers.
package stopwatch_display_driver_pkg;

  localparam logic [7:0] REG_DIGIT0    = 8'h01;
  localparam logic [7:0] REG_DIGIT1    = 8'h02;
  localparam logic [7:0] REG_DIGIT2    = 8'h03;
  localparam logic [7:0] REG_DIGIT3    = 8'h04;
  localparam logic [7:0] REG_DIGIT4    = 8'h05;
  localparam logic [7:0] REG_DIGIT5    = 8'h06;
  localparam logic [7:0] REG_DECODE    = 8'h09;
  localparam logic [7:0] REG_INTENSITY = 8'h0A;
  localparam logic [7:0] REG_SCANLIMIT = 8'h0B;
  localparam logic [7:0] REG_SHUTDOWN  = 8'h0C;
  localparam logic [7:0] REG_TEST      = 8'h0F;

  localparam logic [7:0] INIT_SHUTDOWN_OFF = 8'h01;
  localparam logic [7:0] INIT_TEST_OFF     = 8'h00;
  localparam logic [7:0] INIT_DECODE_ALL   = 8'hFF;
  localparam logic [7:0] INIT_SCAN_0_5     = 8'h05;

  localparam logic [3:0] DP_NIBBLE = 4'h8;

  localparam int INIT_FRAMES  = 5;
  localparam int DIGIT_FRAMES = 6;

  typedef enum logic [2:0] {
    CTL_RESET,
    CTL_INIT,
    CTL_IDLE,
    CTL_LOAD,
    CTL_SEND
  } ctl_state_e;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_SHIFT,
    TX_TAIL
  } tx_state_e;

  typedef struct packed {
    logic [2:0] min_x0;
    logic [3:0] min_0x;
    logic [2:0] sec_x0;
    logic [3:0] sec_0x;
    logic [3:0] ces_x0;
    logic [3:0] ces_0x;
  } digits_t;

  function automatic logic [15:0] init_frame(input logic [2:0] idx, input logic [3:0] intensity);
    logic [15:0] w;
    case (idx)
      3'd0:    w = {REG_SHUTDOWN, INIT_SHUTDOWN_OFF};
      3'd1:    w = {REG_TEST, INIT_TEST_OFF};
      3'd2:    w = {REG_DECODE, INIT_DECODE_ALL};
      3'd3:    w = {REG_SCANLIMIT, INIT_SCAN_0_5};
      default: w = {REG_INTENSITY, 4'h0, intensity};
    endcase
    return w;
  endfunction

  // Decimal points sit on digits 3 and 5 (seconds and minutes units).
  function automatic logic [15:0] digit_frame(input logic [2:0] idx, input digits_t d);
    logic [15:0] w;
    case (idx)
      3'd0:    w = {REG_DIGIT0, 4'h0, d.ces_0x};
      3'd1:    w = {REG_DIGIT1, 4'h0, d.ces_x0};
      3'd2:    w = {REG_DIGIT2, DP_NIBBLE, d.sec_0x};
      3'd3:    w = {REG_DIGIT3, 5'h00, d.sec_x0};
      3'd4:    w = {REG_DIGIT4, DP_NIBBLE, d.min_0x};
      default: w = {REG_DIGIT5, 5'h00, d.min_x0};
    endcase
    return w;
  endfunction

endpackage

// File: rtl/stopwatch_display_driver_spi_frame_tx.sv
// 16-bit MSB-first frame transmitter for the MAX7219 3-wire interface.
// start_i is accepted only when idle; done_o pulses one cycle after the frame tail.
module spi_frame_tx
  import stopwatch_display_driver_pkg::*;
#(
  parameter int CLK_DIV = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_i,
  input  logic [15:0] data_i,
  output logic        done_o,
  output logic        cs_n_o,
  output logic        sclk_o,
  output logic        mosi_o
);

  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

  tx_state_e   state_q;
  logic [15:0] shreg_q;
  logic [7:0]  div_q;
  logic [3:0]  bit_q;
  logic        cs_n_q, sclk_q, mosi_q, done_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= TX_IDLE;
      shreg_q <= '0;
      div_q   <= '0;
      bit_q   <= '0;
      cs_n_q  <= 1'b1;
      sclk_q  <= 1'b0;
      mosi_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        TX_IDLE: begin
          if (start_i) begin
            state_q <= TX_SHIFT;
            cs_n_q  <= 1'b0;
            sclk_q  <= 1'b0;
            mosi_q  <= data_i[15];
            shreg_q <= {data_i[14:0], 1'b0};
            div_q   <= '0;
            bit_q   <= '0;
          end
        end
        TX_SHIFT: begin
          if (div_q == DIV_LAST) begin
            div_q <= '0;
            if (!sclk_q) begin
              sclk_q <= 1'b1;
            end else if (bit_q == 4'd15) begin
              cs_n_q  <= 1'b1;
              sclk_q  <= 1'b0;
              state_q <= TX_TAIL;
            end else begin
              // mosi only moves on the falling sclk edge
              sclk_q  <= 1'b0;
              mosi_q  <= shreg_q[15];
              shreg_q <= {shreg_q[14:0], 1'b0};
              bit_q   <= bit_q + 4'd1;
            end
          end else begin
            div_q <= div_q + 8'd1;
          end
        end
        TX_TAIL: begin
          if (div_q == DIV_LAST) begin
            div_q   <= '0;
            done_q  <= 1'b1;
            state_q <= TX_IDLE;
          end else begin
            div_q <= div_q + 8'd1;
          end
        end
        default: state_q <= TX_IDLE;
      endcase
    end
  end

  assign done_o = done_q;
  assign cs_n_o = cs_n_q;
  assign sclk_o = sclk_q;
  assign mosi_o = mosi_q;

endmodule

// File: rtl/stopwatch_display_driver.sv
// Stopwatch MM:SS.CC display driver: initialises a MAX7219 after reset, then
// sends the six digit registers from a snapshot on every update request.
module stopwatch_display_driver
  import stopwatch_display_driver_pkg::*;
#(
  parameter int CLK_DIV   = 2,
  parameter int INTENSITY = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       update,
  input  logic [2:0] min_X0,
  input  logic [3:0] min_0X,
  input  logic [2:0] sec_X0,
  input  logic [3:0] sec_0X,
  input  logic [3:0] ces_X0,
  input  logic [3:0] ces_0X,
  output logic       cs_n,
  output logic       sclk,
  output logic       mosi,
  output logic       busy
);

  localparam logic [3:0] INTENSITY_L = 4'(INTENSITY);
  localparam logic [2:0] INIT_LAST   = 3'(INIT_FRAMES - 1);
  localparam logic [2:0] DIGIT_LAST  = 3'(DIGIT_FRAMES - 1);

  ctl_state_e  state_q;
  logic [2:0]  idx_q;
  digits_t     snap_q;
  logic        pending_q, busy_q, start_q;
  logic        tx_done;
  logic [15:0] frame_d;

  always_comb begin
    frame_d = init_frame(idx_q, INTENSITY_L);
    if (state_q == CTL_SEND) frame_d = digit_frame(idx_q, snap_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= CTL_RESET;
      idx_q     <= '0;
      snap_q    <= '0;
      pending_q <= 1'b0;
      busy_q    <= 1'b1;
      start_q   <= 1'b0;
    end else begin
      start_q <= 1'b0;
      case (state_q)
        CTL_RESET: begin
          state_q <= CTL_INIT;
          idx_q   <= '0;
          start_q <= 1'b1;
        end
        CTL_INIT: begin
          if (update) pending_q <= 1'b1;
          if (tx_done) begin
            if (idx_q == INIT_LAST) begin
              state_q <= CTL_IDLE;
              idx_q   <= '0;
              busy_q  <= pending_q | update;
            end else begin
              idx_q   <= idx_q + 3'd1;
              start_q <= 1'b1;
            end
          end
        end
        CTL_IDLE: begin
          if (update || pending_q) begin
            state_q <= CTL_LOAD;
            busy_q  <= 1'b1;
          end
        end
        CTL_LOAD: begin
          // A request arriving in this very cycle must still queue a follow-up pass.
          snap_q    <= {min_X0, min_0X, sec_X0, sec_0X, ces_X0, ces_0X};
          pending_q <= update;
          state_q   <= CTL_SEND;
          idx_q     <= '0;
          start_q   <= 1'b1;
        end
        CTL_SEND: begin
          if (update) pending_q <= 1'b1;
          if (tx_done) begin
            if (idx_q == DIGIT_LAST) begin
              state_q <= CTL_IDLE;
              idx_q   <= '0;
              busy_q  <= pending_q | update;
            end else begin
              idx_q   <= idx_q + 3'd1;
              start_q <= 1'b1;
            end
          end
        end
        default: state_q <= CTL_RESET;
      endcase
    end
  end

  spi_frame_tx #(.CLK_DIV(CLK_DIV)) u_tx (
    .clk     (clk),
    .rst     (rst),
    .start_i (start_q),
    .data_i  (frame_d),
    .done_o  (tx_done),
    .cs_n_o  (cs_n),
    .sclk_o  (sclk),
    .mosi_o  (mosi)
  );

  assign busy = busy_q;

endmodule

// File: tb/tb_stopwatch_display_driver.sv
// Directed bench: decodes the serial frames of two driver instances (CLK_DIV=2 and 1)
// and checks words, cs_n timing, busy and pending behaviour.
module tb_stopwatch_display_driver;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst0, rst1, update0, update1;
  logic [2:0] min_x0, sec_x0;
  logic [3:0] min_0x, sec_0x, ces_x0, ces_0x;
  logic       cs_n0, sclk0, mosi0, busy0;
  logic       cs_n1, sclk1, mosi1, busy1;

  stopwatch_display_driver #(.CLK_DIV(2), .INTENSITY(8)) dut0 (
    .clk(clk), .rst(rst0), .update(update0),
    .min_X0(min_x0), .min_0X(min_0x), .sec_X0(sec_x0), .sec_0X(sec_0x),
    .ces_X0(ces_x0), .ces_0X(ces_0x),
    .cs_n(cs_n0), .sclk(sclk0), .mosi(mosi0), .busy(busy0)
  );

  stopwatch_display_driver #(.CLK_DIV(1), .INTENSITY(3)) dut1 (
    .clk(clk), .rst(rst1), .update(update1),
    .min_X0(min_x0), .min_0X(min_0x), .sec_X0(sec_x0), .sec_0X(sec_0x),
    .ces_X0(ces_x0), .ces_0X(ces_0x),
    .cs_n(cs_n1), .sclk(sclk1), .mosi(mosi1), .busy(busy1)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // frame monitors, sampled on the falling clk edge
  logic [15:0] frm0_q[$], frm1_q[$];
  int          fall0_q[$], fall1_q[$], low0_q[$], low1_q[$];
  logic [15:0] sh0, sh1;
  int          bc0 = 0, bc1 = 0, ft0 = 0, ft1 = 0, mv0 = 0, mv1 = 0;
  logic        pcs0 = 1'b1, pcs1 = 1'b1, psc0 = 1'b0, psc1 = 1'b0, pmo0 = 1'b0, pmo1 = 1'b0;
  int          last_fall0 = 0, last_fall1 = 0;

  always @(negedge clk) begin
    if (rst0) begin
      bc0 <= 0; pcs0 <= 1'b1; psc0 <= 1'b0;
    end else begin
      if (pcs0 && !cs_n0) ft0 <= cyc;
      if (!cs_n0 && sclk0 && !psc0) begin
        sh0 <= {sh0[14:0], mosi0};
        bc0 <= bc0 + 1;
        if (mosi0 !== pmo0) mv0 <= mv0 + 1;
      end
      if (!pcs0 && cs_n0) begin
        if (bc0 == 16) begin
          frm0_q.push_back(sh0); fall0_q.push_back(ft0); low0_q.push_back(cyc - ft0);
        end
        bc0 <= 0;
      end
      pcs0 <= cs_n0; psc0 <= sclk0;
    end
    pmo0 <= mosi0;
  end

  always @(negedge clk) begin
    if (rst1) begin
      bc1 <= 0; pcs1 <= 1'b1; psc1 <= 1'b0;
    end else begin
      if (pcs1 && !cs_n1) ft1 <= cyc;
      if (!cs_n1 && sclk1 && !psc1) begin
        sh1 <= {sh1[14:0], mosi1};
        bc1 <= bc1 + 1;
        if (mosi1 !== pmo1) mv1 <= mv1 + 1;
      end
      if (!pcs1 && cs_n1) begin
        if (bc1 == 16) begin
          frm1_q.push_back(sh1); fall1_q.push_back(ft1); low1_q.push_back(cyc - ft1);
        end
        bc1 <= 0;
      end
      pcs1 <= cs_n1; psc1 <= sclk1;
    end
    pmo1 <= mosi1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // pops one decoded frame; per=0 skips the fall-to-fall interval check
  task automatic exp_frame(input int inst, input string tag, input logic [15:0] exp,
                           input int per, input int low);
    logic [15:0] w;
    int f, l, prev;
    w = 'x; f = -1; l = -1;
    if (inst == 0 && frm0_q.size() > 0) begin
      w = frm0_q.pop_front(); f = fall0_q.pop_front(); l = low0_q.pop_front();
    end else if (inst == 1 && frm1_q.size() > 0) begin
      w = frm1_q.pop_front(); f = fall1_q.pop_front(); l = low1_q.pop_front();
    end
    prev = (inst == 0) ? last_fall0 : last_fall1;
    check({tag, " word"}, 32'(w), 32'(exp));
    check({tag, " cs_n low"}, l, low);
    if (per != 0) check({tag, " fall spacing"}, f - prev, per);
    if (inst == 0) last_fall0 = f; else last_fall1 = f;
  endtask

  task automatic wait_idle(input int inst, input int budget, input string tag);
    int n = 0;
    while (((inst == 0) ? busy0 : busy1) && n < budget) begin
      @(negedge clk); n++;
    end
    check({tag, " busy falls"}, 32'((inst == 0) ? busy0 : busy1), 32'd0);
  endtask

  task automatic pulse(input int inst);
    if (inst == 0) update0 = 1'b1; else update1 = 1'b1;
    @(negedge clk);
    update0 = 1'b0; update1 = 1'b0;
  endtask

  task automatic set_digits(input logic [2:0] mt, input logic [3:0] mu, input logic [2:0] st,
                            input logic [3:0] su, input logic [3:0] ct, input logic [3:0] cu);
    min_x0 = mt; min_0x = mu; sec_x0 = st; sec_0x = su; ces_x0 = ct; ces_0x = cu;
  endtask

  task automatic exp_init(input int inst, input string tag, input logic [15:0] last_word);
    int per = (inst == 0) ? 68 : 35;
    int low = (inst == 0) ? 64 : 32;
    exp_frame(inst, {tag, " shutdown"}, 16'h0C01, 0, low);
    exp_frame(inst, {tag, " test"}, 16'h0F00, per, low);
    exp_frame(inst, {tag, " decode"}, 16'h09FF, per, low);
    exp_frame(inst, {tag, " scan"}, 16'h0B05, per, low);
    exp_frame(inst, {tag, " intensity"}, last_word, per, low);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, drops;
    rst0 = 1'b1; rst1 = 1'b1; update0 = 1'b0; update1 = 1'b0;
    set_digits(3'd0, 4'd0, 3'd0, 4'd0, 4'd0, 4'd0);
    repeat (3) @(negedge clk);

    check("reset cs_n", 32'(cs_n0), 32'd1);
    check("reset sclk", 32'(sclk0), 32'd0);
    check("reset mosi", 32'(mosi0), 32'd0);
    check("reset busy", 32'(busy0), 32'd1);
    check("reset pending", 32'(dut0.pending_q), 32'd0);
    check("reset snapshot", 32'(dut0.snap_q), 32'd0);
    check("reset cs_n div1", 32'(cs_n1), 32'd1);

    // init sequence after reset release
    rst0 = 1'b0;
    @(negedge clk);
    check("cs_n high on first released edge", 32'(cs_n0), 32'd1);
    @(negedge clk);
    check("first init frame cs_n fall", 32'(cs_n0), 32'd0);
    drops = 0; n = 0;
    while (frm0_q.size() < 5 && n < 2000) begin
      @(negedge clk); n++;
      if (!busy0) drops++;
    end
    check("busy held during init", drops, 0);
    wait_idle(0, 200, "init");
    exp_init(0, "init", 16'h0A08);
    check("init frame count", frm0_q.size(), 0);

    // update pass 12:34.56
    set_digits(3'd1, 4'd2, 3'd3, 4'd4, 4'd5, 4'd6);
    pulse(0);
    check("busy rises on LOAD", 32'(busy0), 32'd1);
    wait_idle(0, 1000, "pass1");
    exp_frame(0, "p1 d0", 16'h0106, 0, 64);
    exp_frame(0, "p1 d1", 16'h0205, 68, 64);
    exp_frame(0, "p1 d2", 16'h0384, 68, 64);
    exp_frame(0, "p1 d3", 16'h0403, 68, 64);
    exp_frame(0, "p1 d4", 16'h0582, 68, 64);
    exp_frame(0, "p1 d5", 16'h0601, 68, 64);

    // digits change during the third frame must not leak into the pass
    pulse(0);
    n = 0;
    while (!(frm0_q.size() == 2 && cs_n0 == 1'b0) && n < 1000) begin
      @(negedge clk); n++;
    end
    check("third frame reached", 32'(n < 1000), 32'd1);
    set_digits(3'd5, 4'd9, 3'd5, 4'd9, 4'd9, 4'd9);
    wait_idle(0, 1000, "pass2");
    exp_frame(0, "snap d0", 16'h0106, 0, 64);
    exp_frame(0, "snap d1", 16'h0205, 68, 64);
    exp_frame(0, "snap d2", 16'h0384, 68, 64);
    exp_frame(0, "snap d3", 16'h0403, 68, 64);
    exp_frame(0, "snap d4", 16'h0582, 68, 64);
    exp_frame(0, "snap d5", 16'h0601, 68, 64);
    repeat (200) @(negedge clk);
    check("no extra pass after snapshot test", frm0_q.size(), 0);

    // three requests during a pass collapse into one follow-up pass
    set_digits(3'd0, 4'd1, 3'd0, 4'd2, 4'd0, 4'd3);
    pulse(0);
    n = 0;
    while (frm0_q.size() < 1 && n < 1000) begin
      @(negedge clk); n++;
    end
    pulse(0); repeat (5) @(negedge clk);
    pulse(0); repeat (5) @(negedge clk);
    pulse(0);
    check("pending set during pass", 32'(dut0.pending_q), 32'd1);
    set_digits(3'd4, 4'd5, 3'd5, 4'd1, 4'd2, 4'hC);
    drops = 0; n = 0;
    while (frm0_q.size() < 12 && n < 3000) begin
      @(negedge clk); n++;
      if (!busy0) drops++;
    end
    check("busy held between passes", drops, 0);
    wait_idle(0, 1000, "collapse");
    exp_frame(0, "c1 d0", 16'h0103, 0, 64);
    exp_frame(0, "c1 d1", 16'h0200, 68, 64);
    exp_frame(0, "c1 d2", 16'h0382, 68, 64);
    exp_frame(0, "c1 d3", 16'h0400, 68, 64);
    exp_frame(0, "c1 d4", 16'h0581, 68, 64);
    exp_frame(0, "c1 d5", 16'h0600, 68, 64);
    exp_frame(0, "c2 d0", 16'h010C, 0, 64);
    exp_frame(0, "c2 d1", 16'h0202, 68, 64);
    exp_frame(0, "c2 d2", 16'h0381, 68, 64);
    exp_frame(0, "c2 d3", 16'h0405, 68, 64);
    exp_frame(0, "c2 d4", 16'h0585, 68, 64);
    exp_frame(0, "c2 d5", 16'h0604, 68, 64);
    repeat (300) @(negedge clk);
    check("exactly one follow-up pass", frm0_q.size(), 0);

    // reset in the middle of the second frame of a pass
    pulse(0);
    n = 0;
    while (!(frm0_q.size() >= 1 && cs_n0 == 1'b0) && n < 1000) begin
      @(negedge clk); n++;
    end
    repeat (10) @(negedge clk);
    pulse(0);
    check("pending before mid-frame reset", 32'(dut0.pending_q), 32'd1);
    rst0 = 1'b1;
    @(negedge clk);
    check("mid reset cs_n", 32'(cs_n0), 32'd1);
    check("mid reset sclk", 32'(sclk0), 32'd0);
    check("mid reset busy", 32'(busy0), 32'd1);
    check("mid reset pending", 32'(dut0.pending_q), 32'd0);
    repeat (2) @(negedge clk);
    frm0_q.delete(); fall0_q.delete(); low0_q.delete();
    rst0 = 1'b0;
    @(negedge clk);
    wait_idle(0, 1000, "reinit");
    exp_init(0, "reinit", 16'h0A08);
    repeat (300) @(negedge clk);
    check("no pass after reinit", frm0_q.size(), 0);
    check("pending clear after reinit", 32'(dut0.pending_q), 32'd0);

    // CLK_DIV=1 instance, INTENSITY=3
    set_digits(3'd2, 4'd3, 3'd4, 4'd5, 4'd6, 4'd7);
    rst1 = 1'b0;
    @(negedge clk);
    check("div1 cs_n high on first released edge", 32'(cs_n1), 32'd1);
    @(negedge clk);
    check("div1 first frame cs_n fall", 32'(cs_n1), 32'd0);
    wait_idle(1, 1000, "div1 init");
    exp_init(1, "div1 init", 16'h0A03);
    pulse(1);
    check("div1 busy rises", 32'(busy1), 32'd1);
    wait_idle(1, 1000, "div1 pass");
    exp_frame(1, "div1 d0", 16'h0107, 0, 32);
    exp_frame(1, "div1 d1", 16'h0206, 35, 32);
    exp_frame(1, "div1 d2", 16'h0385, 35, 32);
    exp_frame(1, "div1 d3", 16'h0404, 35, 32);
    exp_frame(1, "div1 d4", 16'h0583, 35, 32);
    exp_frame(1, "div1 d5", 16'h0602, 35, 32);

    check("mosi stable at sclk rise div2", mv0, 0);
    check("mosi stable at sclk rise div1", mv1, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
